// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction SRAM port plus IF->ID handshake.
// master = fetch_unit, slave = SRAM model / decode stage.
interface fetch_unit_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
);
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ren;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;

  modport master (
    output imem_addr,
    output imem_ren,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    input  imem_ren,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns fetch PC, drives 1-cycle SRAM, queues words.
// Ports: clk, rst (sync high), enable, redirect_valid/pc, bus (fetch_unit_if.master).
module fetch_unit #(
  parameter int             PC_W     = 64,
  parameter int             INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int             DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  fetch_unit_if.master    bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] req_pc;

  logic            valid;
  logic            pop;
  logic            push;
  logic            issue;
  logic [OW-1:0]   occ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid = (count != '0);
  assign pop   = valid & bus.out_ready & enable;
  assign push  = enable & inflight & ~redirect_valid;

  // Slots already promised: queued words plus the one in flight,
  // minus the head leaving this cycle. pop implies count>=1.
  assign occ   = {1'b0, count} + OW'(inflight) - OW'(pop);
  assign issue = enable & ~rst & ~redirect_valid
               & (occ < OW'(DEPTH));

  assign bus.imem_addr = fetch_pc;
  assign bus.imem_ren  = issue;
  assign bus.out_valid = valid;
  assign bus.out_instr = valid ? mem[head].instr : '0;
  assign bus.out_pc    = valid ? mem[head].pc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (enable) begin
      if (redirect_valid) begin
        // Pop (if any) already happened in ID; drop everything else.
        fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
        inflight <= 1'b0;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (issue) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + PC_W'(4);
        end
        inflight <= issue;
        if (push) begin
          mem[tail] <= '{pc: req_pc, instr: bus.imem_rdata};
          tail      <= nxt(tail);
        end
        if (pop)
          head <= nxt(head);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives the instruction SRAM, which has a 1-cycle synchronous read.
- Buffers returned words in a small queue and presents {pc, instruction} to ID over a valid/ready handshake.
- Accepts a branch/jump redirect, flushes wrong-path work and resumes fetching at the target.

Parameters:
- PC_W, 64, width of PC and instruction-memory address.
- INSTR_W, 32, instruction word width.
- RESET_PC, 0, first fetch address after reset.
- DEPTH, 2, fetch-queue entries; minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  global run enable; 0 freezes all state.
- redirect_valid  in  1  branch/jump taken; has priority over normal fetch.
- redirect_pc  in  PC_W  redirect target; bits [1:0] are forced to 0.
- imem_addr  out  PC_W  SRAM read address, equal to fetch_pc.
- imem_ren  out  1  SRAM read enable, asserted on the issue cycle.
- imem_rdata  in  INSTR_W  SRAM data, valid the cycle after the issue.
- out_valid  out  1  queue head valid.
- out_ready  in  1  ID accepts the head; ID stall drives this low.
- out_instr  out  INSTR_W  head instruction; 0 when the queue is empty.
- out_pc  out  PC_W  head PC; 0 when the queue is empty.

Behaviour:
- Reset (rst=1 at a clock edge, which overrides every other input):
  - fetch_pc=RESET_PC, count=0, inflight=0.
  - imem_ren=0 while rst=1; out_valid=0, out_instr=0, out_pc=0.
- Definitions:
  - pop = out_valid & out_ready & enable.
  - issue = enable & !rst & !redirect_valid & ((count + inflight - pop) < DEPTH).
  - imem_ren = issue.
- Issue and response:
  - On issue: req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (wraps modulo 2^PC_W), inflight <= 1.
  - Without an issue, inflight <= 0 once a response is consumed.
  - Response: when inflight=1 and no redirect this cycle, push {req_pc, imem_rdata} at the tail.
  - A push and a pop in the same cycle are both performed and count is unchanged.
- Queue:
  - Circular buffer; head/tail pointers wrap at DEPTH.
  - count never exceeds DEPTH; the issue rule guarantees every response has a free slot.
- Throughput: with out_ready held at 1, one instruction per cycle in steady state.
- Latency: first out_valid comes 2 cycles after the issue of RESET_PC, i.e. the 3rd cycle after rst deasserts.
- Redirect (redirect_valid=1, enable=1):
  - Any pop in the same cycle still completes; ID has taken that instruction.
  - Then the queue is flushed (count=0, pointers reset) and inflight <= 0.
  - The response arriving on the following cycle is discarded.
  - fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00}; no issue on the redirect cycle.
  - The target is issued the next cycle; out_valid with out_pc = target comes 2 cycles after that issue.
  - Back-to-back redirects: the last one wins.
- enable=0:
  - No issue, push, pop, redirect or pointer change; imem_ren=0.
  - An outstanding inflight stays pending; the SRAM holds its rdata while ren=0.
  - out_valid/out_instr/out_pc keep showing the current head.
- rst mid-operation: queue and inflight are discarded and fetching restarts at RESET_PC.
- out_instr/out_pc are driven combinationally from the head entry.

Test Plan:
- Reset, then out_ready=1, with the SRAM model returning 0x00000013 + (addr<<8): out_pc 0x0, 0x4, 0x8 … on consecutive cycles from the 3rd cycle after reset; out_instr matches the model.
- Hold out_ready=0 for 6 cycles: count=2, imem_ren=0 after the queue fills, head stays pc 0x0 stable. On release, PCs stay contiguous with none lost or duplicated.
- Queue full (pcs 0x8, 0xC), redirect_valid=1 with redirect_pc=0x103: out_valid=0 next cycle, imem_addr=0x100, then out_pc=0x100, 0x104.
- Redirect while a fetch is in flight: the stale word is never presented; the first out_pc after the redirect equals the target.
- Hold enable=0 for 4 cycles mid-stream: no imem_ren and outputs frozen. After enable returns, the next PC equals the pre-freeze fetch_pc.
- Assert rst together with redirect_valid=1 (target 0x200): the restart fetches RESET_PC=0x0, not 0x200; out_valid=0 during rst.
